nn_infer_ctrl: RTL

NN_INFER_CTRL -- requirements
Module: nn_infer_ctrl

---
 rtl/nn_ctrl_pkg.sv | 24 ++
 rtl/stage_watchdog.sv | 39 +++
 rtl/nn_infer_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared state encoding, default parameter values and sizing helper for the
// inference sequencer.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAYER,
    ST_HM_CLEAR,
    ST_HM_RUN,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int DEF_NUM_LAYERS     = 3;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_NUM_OUTPUTS    = 10;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle counter; flags expiry on the last permitted cycle of a stage.
module stage_watchdog
  import nn_ctrl_pkg::*;
#(
  parameter int timeoutCycles = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = idx_width(timeoutCycles);
  localparam logic [CW-1:0] LAST = CW'(timeoutCycles - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = run && (count_q == LAST);

  // Saturate at LAST so a stalled stage never wraps back into a valid window.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nn_infer_ctrl.sv
// Sequences the layer stages and the hardmax unit for one inference and holds
// the classification result until it is accepted.
module nn_infer_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int numLayers     = DEF_NUM_LAYERS,
  parameter int dataWidth     = DEF_DATA_WIDTH,
  parameter int numOutputs    = DEF_NUM_OUTPUTS,
  parameter int timeoutCycles = DEF_TIMEOUT_CYCLES,
  parameter int addressWidth  = $clog2(numOutputs)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic [numLayers-1:0]    layerEnable,
  input  logic [numLayers-1:0]    layerDone,
  output logic                    hmReset,
  output logic                    hmEnable,
  input  logic                    hmValid,
  input  logic [addressWidth-1:0] hmIndex,
  input  logic [dataWidth-1:0]    hmValue,
  output logic [addressWidth-1:0] resultIndex,
  output logic [dataWidth-1:0]    resultValue,
  output logic                    resultValid,
  input  logic                    resultReady,
  output logic                    error
);

  localparam int LW = idx_width(numLayers);
  localparam logic [LW-1:0] LAST_LAYER = LW'(numLayers - 1);

  state_e                  state_q, state_d;
  logic [LW-1:0]           layer_idx_q, layer_idx_d;
  logic [addressWidth-1:0] result_index_q, result_index_d;
  logic [dataWidth-1:0]    result_value_q, result_value_d;
  logic                    wd_run, wd_clear, wd_expired;

  // Counter restarts whenever the stage (state or active layer) changes.
  assign wd_run   = (state_q == ST_LAYER) || (state_q == ST_HM_RUN);
  assign wd_clear = !wd_run || (state_d != state_q) || (layer_idx_d != layer_idx_q);

  stage_watchdog #(
    .timeoutCycles(timeoutCycles)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .run    (wd_run),
    .expired(wd_expired)
  );

  // Completion is tested before expiry so a last-cycle completion still advances.
  always_comb begin
    state_d        = state_q;
    layer_idx_d    = layer_idx_q;
    result_index_d = result_index_q;
    result_value_d = result_value_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_LAYER;
          layer_idx_d = '0;
        end
      end
      ST_LAYER: begin
        if (layerDone[layer_idx_q]) begin
          if (layer_idx_q == LAST_LAYER) begin
            state_d = ST_HM_CLEAR;
          end else begin
            layer_idx_d = layer_idx_q + LW'(1);
          end
        end else if (wd_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_HM_CLEAR: state_d = ST_HM_RUN;
      ST_HM_RUN: begin
        if (hmValid) begin
          state_d        = ST_DONE;
          result_index_d = hmIndex;
          result_value_d = hmValue;
        end else if (wd_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_DONE: begin
        if (resultReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      layer_idx_q    <= '0;
      result_index_q <= '0;
      result_value_q <= '0;
    end else begin
      state_q        <= state_d;
      layer_idx_q    <= layer_idx_d;
      result_index_q <= result_index_d;
      result_value_q <= result_value_d;
    end
  end

  for (genvar gi = 0; gi < numLayers; gi++) begin : g_layer_en
    assign layerEnable[gi] = (state_q == ST_LAYER) && (layer_idx_q == LW'(gi));
  end

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign hmReset     = (state_q == ST_HM_CLEAR);
  assign hmEnable    = (state_q == ST_HM_RUN);
  assign resultValid = (state_q == ST_DONE);
  assign error       = (state_q == ST_ERROR);
  assign resultIndex = result_index_q;
  assign resultValue = result_value_q;

endmodule
